// File: rtl/ldl_rr_pri_v2.sv
// Registered multi-class round-robin arbiter with a ready/last hold, one RR pointer per class.
// Optional starvation aging is enabled by defining LDL_RR_PRI_AGING_EN.
module ldl_rr_pri_v2 #(
   parameter  int unsigned BIN_WIDTH = 3,
   parameter  int unsigned COS_WIDTH = 2,
   parameter  int unsigned AGE_WIDTH = 4,
   parameter  int unsigned AGE_LIMIT = 8,
   localparam int unsigned REQ_WIDTH = 1 << BIN_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [REQ_WIDTH-1:0]           req_i,
   input  logic [REQ_WIDTH*COS_WIDTH-1:0] cos_i,
   input  logic                           ready_i,
   input  logic                           last_i,
   output logic [REQ_WIDTH-1:0]           hot_o,
   output logic [BIN_WIDTH-1:0]           bin_o,
   output logic [COS_WIDTH-1:0]           gnt_cos_o,
   output logic                           valid_o
);

   localparam int unsigned NCOS = 1 << COS_WIDTH;

   typedef enum logic {ST_IDLE, ST_GRANT} state_e;

   state_e                 state_q, state_d;
   logic [REQ_WIDTH-1:0]   hot_q, hot_d;
   logic [BIN_WIDTH-1:0]   bin_q, bin_d;
   logic [COS_WIDTH-1:0]   gnt_cos_q, gnt_cos_d;
   logic [BIN_WIDTH-1:0]   ptr_q [NCOS];
   logic [BIN_WIDTH-1:0]   ptr_d [NCOS];

   logic                   accept_c;
   logic                   any_c;
   logic [COS_WIDTH-1:0]   max_cos_c;
   logic [BIN_WIDTH-1:0]   win_c;
   logic [COS_WIDTH-1:0]   eff_cos_c [REQ_WIDTH];

   assign accept_c = (state_q == ST_GRANT) && ready_i && last_i;

`ifdef LDL_RR_PRI_AGING_EN
   logic [AGE_WIDTH-1:0] age_q [REQ_WIDTH];
   logic [AGE_WIDTH-1:0] age_d [REQ_WIDTH];

   // Waiting sources age on every foreign accept; a saturated source is promoted to the top class.
   always_comb begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
         age_d[i] = age_q[i];
         if (!req_i[i]) begin
            age_d[i] = '0;
         end else if (accept_c) begin
            if (BIN_WIDTH'(i) == bin_q) begin
               age_d[i] = '0;
            end else if (age_q[i] != AGE_WIDTH'(AGE_LIMIT)) begin
               age_d[i] = age_q[i] + 1'b1;
            end
         end
         eff_cos_c[i] = (age_d[i] == AGE_WIDTH'(AGE_LIMIT)) ? '1
                                                            : cos_i[i*COS_WIDTH +: COS_WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REQ_WIDTH; i++) age_q[i] <= '0;
      end else begin
         for (int i = 0; i < REQ_WIDTH; i++) age_q[i] <= age_d[i];
      end
   end
`else
   logic [AGE_WIDTH-1:0] unused_age_limit;
   assign unused_age_limit = AGE_WIDTH'(AGE_LIMIT);

   always_comb begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
         eff_cos_c[i] = cos_i[i*COS_WIDTH +: COS_WIDTH];
      end
   end
`endif

   // Highest active class, then first candidate at or above that class's post-update pointer.
   always_comb begin
      for (int c = 0; c < NCOS; c++) ptr_d[c] = ptr_q[c];
      if (accept_c) ptr_d[gnt_cos_q] = bin_q + 1'b1;

      any_c     = 1'b0;
      max_cos_c = '0;
      for (int i = 0; i < REQ_WIDTH; i++) begin
         if (req_i[i] && (!any_c || (eff_cos_c[i] > max_cos_c))) begin
            any_c     = 1'b1;
            max_cos_c = eff_cos_c[i];
         end
      end

      win_c = '0;
      begin : search
         logic                 found;
         logic [BIN_WIDTH-1:0] idx;
         found = 1'b0;
         for (int k = 0; k < REQ_WIDTH; k++) begin
            idx = ptr_d[max_cos_c] + BIN_WIDTH'(k);
            if (!found && req_i[idx] && (eff_cos_c[idx] == max_cos_c)) begin
               found = 1'b1;
               win_c = idx;
            end
         end
      end
   end

   // Next-state and grant register inputs.
   always_comb begin
      state_d   = state_q;
      hot_d     = hot_q;
      bin_d     = bin_q;
      gnt_cos_d = gnt_cos_q;
      unique case (state_q)
         ST_IDLE: begin
            if (any_c) begin
               state_d   = ST_GRANT;
               hot_d     = REQ_WIDTH'(1) << win_c;
               bin_d     = win_c;
               gnt_cos_d = max_cos_c;
            end
         end
         ST_GRANT: begin
            if (accept_c) begin
               if (any_c) begin
                  hot_d     = REQ_WIDTH'(1) << win_c;
                  bin_d     = win_c;
                  gnt_cos_d = max_cos_c;
               end else begin
                  state_d   = ST_IDLE;
                  hot_d     = '0;
                  bin_d     = '0;
                  gnt_cos_d = '0;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            hot_d     = '0;
            bin_d     = '0;
            gnt_cos_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         hot_q     <= '0;
         bin_q     <= '0;
         gnt_cos_q <= '0;
         for (int c = 0; c < NCOS; c++) ptr_q[c] <= '0;
      end else begin
         state_q   <= state_d;
         hot_q     <= hot_d;
         bin_q     <= bin_d;
         gnt_cos_q <= gnt_cos_d;
         for (int c = 0; c < NCOS; c++) ptr_q[c] <= ptr_d[c];
      end
   end

   assign valid_o   = (state_q == ST_GRANT);
   assign hot_o     = hot_q;
   assign bin_o     = bin_q;
   assign gnt_cos_o = gnt_cos_q;

endmodule

// File: doc/ldl_rr_pri_v2.md
Name: ldl_rr_pri_v2

Overview:
Registered, multi-class round-robin arbiter with a ready/last handshake.
- Each requester carries a class of service (cos). The highest active cos always wins.
- Each cos level has its own round-robin pointer, so fairness inside one class is not disturbed by traffic in other classes.
- A grant is held across a multi-beat transfer until the consumer accepts the final beat.
- Sits between N request sources and a shared downstream port (bus master, egress queue).

Parameters:
BIN_WIDTH, 3, log2 of requester count
COS_WIDTH, 2, class width; 0 lowest, all-ones highest
REQ_WIDTH, 1<<BIN_WIDTH, requester count (derived, do not override)
AGE_WIDTH, 4, aging counter width (used only with LDL_RR_PRI_AGING_EN)
AGE_LIMIT, 8, accepted foreign grants before promotion (used only with LDL_RR_PRI_AGING_EN; must be < 2**AGE_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  REQ_WIDTH  request per source; must be held until the source is granted
cos  input  REQ_WIDTH x COS_WIDTH  per-source class, packed, sampled with req
ready  input  1  consumer accepts the current beat
last  input  1  current beat is final; qualified by valid&&ready
hot  output  REQ_WIDTH  one-hot grant, registered
bin  output  BIN_WIDTH  binary index of the granted source, registered
gnt_cos  output  COS_WIDTH  effective class of the granted source, registered
valid  output  1  grant outputs are valid

Behaviour:
- Reset (async assert, sync release):
  - valid=0, hot=0, bin=0, gnt_cos=0.
  - All per-class pointers ptr[0..2**COS_WIDTH-1]=0.
  - All aging counters=0.
- States:
  - IDLE: valid=0.
  - GRANT: valid=1; hot, bin and gnt_cos frozen.
- Arbitration window: open when valid==0, or when valid&&ready&&last (accept).
- Arbitration rule (combinational, evaluated inside the window):
  - M = maximum effective cos among sources with req high.
  - Candidates = sources with req high and effective cos==M.
  - Winner = first candidate at index >= ptr[M], searching upward and wrapping from REQ_WIDTH-1 to 0.
- Latency:
  - req rising in cycle N with valid=0 gives valid=1 in cycle N+1.
  - On an accept in cycle N, the next grant (if any req) is valid in cycle N+1. No bubble.
- Hold rules while in GRANT:
  - Changes to req or cos are ignored.
  - ready without last changes nothing: the beat transfers and the grant is held.
  - valid never deasserts without an accept.
- ready and last while valid==0 are ignored.
- Pointer update: only on accept.
  - ptr[gnt_cos] <= bin+1, modulo REQ_WIDTH.
  - All other class pointers are unchanged.
- Accept cycle: arbitration uses the post-update pointer value, so the just-served source is lowest priority in its class. It may be re-granted immediately if it is the only candidate.
- Accept with no req pending: next state IDLE; valid=0, hot=0, bin=0, gnt_cos=0.
- Outputs are driven only from registers, with no combinational path from req to the outputs.

Optional Feature:
LDL_RR_PRI_AGING_EN
- Defined:
  - One AGE_WIDTH counter per source.
  - On each accept, for every source i that has req[i]==1 and is not the accepted source: age[i] increments, saturating at AGE_LIMIT.
  - The accepted source's counter clears. A source whose req is low clears.
  - While age[i]==AGE_LIMIT, the source's effective cos is all-ones; otherwise it is cos[i].
  - gnt_cos reports the effective cos.
- Undefined:
  - No counters are built.
  - Effective cos equals cos. Aging parameters are unused.

Test Plan:
- Reset mid-grant: valid=1 with bin=5, assert rst_n=0 → same cycle valid=0, hot=0, bin=0. After release with req=0, valid stays 0.
- Class priority: req=8'h11, cos[0]=1, cos[4]=3 → bin=4, gnt_cos=3. After accept, req=8'h01 → bin=0, gnt_cos=1, no idle cycle.
- Intra-class rotation: req=8'hFF, all cos=2, ready=last=1 continuously → bin sequence 0,1,2,...,7,0 on consecutive cycles; only ptr[2] moves.
- Independent pointers:
  - Step 1: run class 1 to ptr[1]=3.
  - Step 2: grant class 3 sources 6 then 7.
  - Step 3: return to class 1 with req=8'hFF → first class-1 grant is bin=3.
- Multi-beat hold: grant bin=2, 4 beats with last on beat 4, req toggling and higher-cos req arriving mid-burst → outputs frozen until beat 4 is accepted; the higher-cos source is granted next cycle.
- Aging (macro on, AGE_LIMIT=8): source 1 at cos=0 competes with sources 2,3 at cos=3 → source 1 is granted after exactly 8 foreign accepts, gnt_cos=3, and its counter clears.
